// File: rtl/map_table_pkg.sv
// ============================================================================
// Module  : sys_defs (package)
// Brief   : Shared register-file sizing and the physical tag type.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package sys_defs;
  localparam int NUM_GEN_REG  = 32;
  localparam int NUM_PHYS_REG = 64;
  localparam int ZERO_REG     = 31;
  localparam int PHYS_REG_W   = $clog2(NUM_PHYS_REG) + 1;

  typedef logic [PHYS_REG_W-1:0] PHYS_REG;
endpackage

`default_nettype wire

// File: rtl/map_table_if.sv
// ============================================================================
// Module  : map_table_if
// Brief   : Rename, completion, commit and recovery bundle for map_table.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface map_table_if #(
  parameter int NUM_GEN_REG  = sys_defs::NUM_GEN_REG,
  parameter int NUM_PHYS_REG = sys_defs::NUM_PHYS_REG
);
  localparam int ARCH_W = $clog2(NUM_GEN_REG);
  localparam int PHYS_W = $clog2(NUM_PHYS_REG) + 1;

  logic              dispatch_en;
  logic              id_no_dest_reg;
  logic [ARCH_W-1:0] dest_arch;
  logic [ARCH_W-1:0] src1_arch;
  logic [ARCH_W-1:0] src2_arch;
  logic [PHYS_W-1:0] free_reg;
  logic              cdb_valid;
  logic [PHYS_W-1:0] cdb_tag;
  logic              retire_en;
  logic [ARCH_W-1:0] retire_arch;
  logic [PHYS_W-1:0] retire_T_new;
  logic              branch_incorrect;
  logic [PHYS_W-1:0] T1;
  logic [PHYS_W-1:0] T2;
  logic              T1_ready;
  logic              T2_ready;
  logic [PHYS_W-1:0] T_old;

  modport master (
    output dispatch_en, id_no_dest_reg, dest_arch, src1_arch, src2_arch, free_reg,
    output cdb_valid, cdb_tag, retire_en, retire_arch, retire_T_new, branch_incorrect,
    input  T1, T2, T1_ready, T2_ready, T_old
  );

  modport slave (
    input  dispatch_en, id_no_dest_reg, dest_arch, src1_arch, src2_arch, free_reg,
    input  cdb_valid, cdb_tag, retire_en, retire_arch, retire_T_new, branch_incorrect,
    output T1, T2, T1_ready, T2_ready, T_old
  );
endinterface

`default_nettype wire

// File: rtl/map_table_entry.sv
// ============================================================================
// Module  : map_table_entry
// Brief   : One speculative map slot: tag + ready bit with CDB wake-up.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module map_table_entry import sys_defs::*; #(
  parameter int                PHYS_W    = PHYS_REG_W,
  parameter logic [PHYS_W-1:0] RESET_TAG = '0
) (
  input  wire logic              clock,
  input  wire logic              reset,
  input  wire logic              write_en,
  input  wire logic [PHYS_W-1:0] write_tag,
  input  wire logic              recover_en,
  input  wire logic [PHYS_W-1:0] recover_tag,
  input  wire logic              cdb_valid,
  input  wire logic [PHYS_W-1:0] cdb_tag,
  output logic      [PHYS_W-1:0] tag,
  output logic                   ready
);
  logic [PHYS_W-1:0] r_tag;
  logic              r_ready;

  // Recovery overrides everything; a fresh rename beats a same-cycle wake-up.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tag   <= RESET_TAG;
      r_ready <= 1'b1;
    end else if (recover_en) begin
      r_tag   <= recover_tag;
      r_ready <= 1'b1;
    end else if (write_en) begin
      r_tag   <= write_tag;
      r_ready <= 1'b0;
    end else if (cdb_valid && (cdb_tag == r_tag)) begin
      r_ready <= 1'b1;
    end
  end

  assign tag   = r_tag;
  assign ready = r_ready;
endmodule

`default_nettype wire

// File: rtl/map_table.sv
// ============================================================================
// Module  : map_table
// Brief   : Register rename map (speculative + architectural) with recovery.
//           Optional macro MT_CDB_BYPASS_EN: same-cycle CDB ready bypass.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module map_table #(
  parameter int NUM_GEN_REG  = sys_defs::NUM_GEN_REG,
  parameter int NUM_PHYS_REG = sys_defs::NUM_PHYS_REG,
  parameter int ZERO_REG     = sys_defs::ZERO_REG
) (
  input wire logic  clock,
  input wire logic  reset,
  map_table_if.slave mt
);
  localparam int                ARCH_W      = $clog2(NUM_GEN_REG);
  localparam int                PHYS_W      = $clog2(NUM_PHYS_REG) + 1;
  localparam logic [PHYS_W-1:0] C_ZERO_TAG  = {1'b0, {(PHYS_W-1){1'b1}}};
  localparam logic [ARCH_W-1:0] C_ZERO_ARCH = ARCH_W'(ZERO_REG);

  logic [PHYS_W-1:0] w_spec_tag   [NUM_GEN_REG];
  logic              w_spec_ready [NUM_GEN_REG];
  logic [PHYS_W-1:0] w_arch_next  [NUM_GEN_REG];
  logic              w_dest_write;
  logic [PHYS_W-1:0] w_tag1;
  logic [PHYS_W-1:0] w_tag2;
  logic              w_ready1;
  logic              w_ready2;
  logic [PHYS_W-1:0] w_t_old;

  assign w_dest_write = mt.dispatch_en && !mt.id_no_dest_reg && (mt.dest_arch != C_ZERO_ARCH);

  for (genvar i = 0; i < NUM_GEN_REG; i++) begin : g_entry
    localparam bit C_IS_ZERO = (i == ZERO_REG);
    logic [PHYS_W-1:0] r_arch_tag;
    logic              w_retire_hit;

    assign w_retire_hit   = mt.retire_en && (mt.retire_arch == ARCH_W'(i)) && !C_IS_ZERO;
    // Recovery copies this next value, so a same-cycle retire is included.
    assign w_arch_next[i] = w_retire_hit ? mt.retire_T_new : r_arch_tag;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_arch_tag <= PHYS_W'(i);
      else        r_arch_tag <= w_arch_next[i];
    end

    map_table_entry #(
      .PHYS_W    (PHYS_W),
      .RESET_TAG (PHYS_W'(i))
    ) u_entry (
      .clock       (clock),
      .reset       (reset),
      .write_en    (w_dest_write && (mt.dest_arch == ARCH_W'(i))),
      .write_tag   (mt.free_reg),
      .recover_en  (mt.branch_incorrect),
      .recover_tag (w_arch_next[i]),
      .cdb_valid   (mt.cdb_valid),
      .cdb_tag     (mt.cdb_tag),
      .tag         (w_spec_tag[i]),
      .ready       (w_spec_ready[i])
    );
  end

  always_comb begin
    w_tag1   = w_spec_tag[mt.src1_arch];
    w_ready1 = w_spec_ready[mt.src1_arch];
    w_tag2   = w_spec_tag[mt.src2_arch];
    w_ready2 = w_spec_ready[mt.src2_arch];
    w_t_old  = w_spec_tag[mt.dest_arch];
    if (mt.src1_arch == C_ZERO_ARCH) begin
      w_tag1   = C_ZERO_TAG;
      w_ready1 = 1'b1;
    end
    if (mt.src2_arch == C_ZERO_ARCH) begin
      w_tag2   = C_ZERO_TAG;
      w_ready2 = 1'b1;
    end
    if (mt.id_no_dest_reg || (mt.dest_arch == C_ZERO_ARCH)) w_t_old = C_ZERO_TAG;
  end

  assign mt.T1    = w_tag1;
  assign mt.T2    = w_tag2;
  assign mt.T_old = w_t_old;

`ifdef MT_CDB_BYPASS_EN
  assign mt.T1_ready = w_ready1 | (mt.cdb_valid && (mt.cdb_tag == w_tag1));
  assign mt.T2_ready = w_ready2 | (mt.cdb_valid && (mt.cdb_tag == w_tag2));
`else
  assign mt.T1_ready = w_ready1;
  assign mt.T2_ready = w_ready2;
`endif
endmodule

`default_nettype wire

// File: tb/tb_map_table.sv
// ============================================================================
// Module  : tb_map_table
// Brief   : Directed and randomized checks of map_table against an array model.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_map_table;
  import sys_defs::*;
  localparam int NG = 32;
  localparam int ZR = 31;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  int m_spec_tag [NG];
  bit m_spec_rdy [NG];
  int m_arch     [NG];

  map_table_if mt_if ();
  map_table dut (.clock(clock), .reset(reset), .mt(mt_if));

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  function automatic void model_reset();
    for (int i = 0; i < NG; i++) begin
      m_spec_tag[i] = i;
      m_spec_rdy[i] = 1'b1;
      m_arch[i]     = i;
    end
  endfunction

  // Next-state rules of both maps, applied once per rising edge.
  function automatic void model_commit();
    int na [NG];
    na = m_arch;
    if (mt_if.retire_en && mt_if.retire_arch != ZR) na[mt_if.retire_arch] = int'(mt_if.retire_T_new);
    if (mt_if.branch_incorrect) begin
      for (int i = 0; i < NG; i++) begin
        m_spec_tag[i] = na[i];
        m_spec_rdy[i] = 1'b1;
      end
    end else begin
      if (mt_if.cdb_valid)
        for (int i = 0; i < NG; i++) if (m_spec_tag[i] == int'(mt_if.cdb_tag)) m_spec_rdy[i] = 1'b1;
      if (mt_if.dispatch_en && !mt_if.id_no_dest_reg && mt_if.dest_arch != ZR) begin
        m_spec_tag[mt_if.dest_arch] = int'(mt_if.free_reg);
        m_spec_rdy[mt_if.dest_arch] = 1'b0;
      end
    end
    m_arch = na;
  endfunction

  function automatic PHYS_REG exp_tag(int a);
    return (a == ZR) ? PHYS_REG'(63) : PHYS_REG'(m_spec_tag[a]);
  endfunction

  function automatic bit exp_rdy(int a, PHYS_REG t);
    bit r;
    r = (a == ZR) ? 1'b1 : m_spec_rdy[a];
`ifdef MT_CDB_BYPASS_EN
    if (mt_if.cdb_valid && mt_if.cdb_tag == t) r = 1'b1;
`else
    if (t == '1) r = r;
`endif
    return r;
  endfunction

  task automatic idle();
    mt_if.dispatch_en = 0; mt_if.id_no_dest_reg = 0; mt_if.dest_arch = '0;
    mt_if.src1_arch = '0; mt_if.src2_arch = '0; mt_if.free_reg = '0;
    mt_if.cdb_valid = 0; mt_if.cdb_tag = '0; mt_if.retire_en = 0;
    mt_if.retire_arch = '0; mt_if.retire_T_new = '0; mt_if.branch_incorrect = 0;
  endtask

  task automatic cycle();
    @(posedge clock);
    model_commit();
    #1;
    idle();
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    mt_if.src1_arch = 5; mt_if.src2_arch = 31; mt_if.dest_arch = 12;
    #12;
    checks++; if (mt_if.T1 !== 7'd5) begin errors++; $display("FAIL rst_hold_T1: got %0d want 5", mt_if.T1); end
    checks++; if (mt_if.T1_ready !== 1'b1) begin errors++; $display("FAIL rst_hold_T1_ready: got %b want 1", mt_if.T1_ready); end
    checks++; if (mt_if.T2 !== 7'd63 || mt_if.T2_ready !== 1'b1) begin errors++; $display("FAIL rst_zero_T2: got %0d/%b want 63/1", mt_if.T2, mt_if.T2_ready); end
    checks++; if (mt_if.T_old !== 7'd12) begin errors++; $display("FAIL rst_T_old: got %0d want 12", mt_if.T_old); end
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    cycle();
    mt_if.src1_arch = 5;
    @(negedge clock);
    checks++; if (mt_if.T1 !== 7'd5 || mt_if.T1_ready !== 1'b1) begin errors++; $display("FAIL rst_release_T1: got %0d/%b want 5/1", mt_if.T1, mt_if.T1_ready); end
    cycle();
  endtask

  task automatic test_rename();
    mt_if.dispatch_en = 1; mt_if.dest_arch = 3; mt_if.free_reg = 40; mt_if.src1_arch = 3;
    @(negedge clock);
    checks++; if (mt_if.T_old !== 7'd3) begin errors++; $display("FAIL rename_T_old: got %0d want 3", mt_if.T_old); end
    checks++; if (mt_if.T1 !== 7'd3) begin errors++; $display("FAIL rename_preupdate_T1: got %0d want 3", mt_if.T1); end
    cycle();
    mt_if.src1_arch = 3;
    @(negedge clock);
    checks++; if (mt_if.T1 !== 7'd40 || mt_if.T1_ready !== 1'b0) begin errors++; $display("FAIL rename_T1: got %0d/%b want 40/0", mt_if.T1, mt_if.T1_ready); end
    cycle();
  endtask

  task automatic test_cdb();
    bit want;
    want = 1'b0;
`ifdef MT_CDB_BYPASS_EN
    want = 1'b1;
`endif
    mt_if.cdb_valid = 1; mt_if.cdb_tag = 40; mt_if.src1_arch = 3;
    @(negedge clock);
    checks++; if (mt_if.T1_ready !== want) begin errors++; $display("FAIL cdb_same_cycle: got %b want %b", mt_if.T1_ready, want); end
    cycle();
    mt_if.src1_arch = 3;
    @(negedge clock);
    checks++; if (mt_if.T1 !== 7'd40 || mt_if.T1_ready !== 1'b1) begin errors++; $display("FAIL cdb_next_cycle: got %0d/%b want 40/1", mt_if.T1, mt_if.T1_ready); end
    cycle();
  endtask

  task automatic test_conflict();
    mt_if.dispatch_en = 1; mt_if.dest_arch = 4; mt_if.free_reg = 41;
    mt_if.cdb_valid = 1; mt_if.cdb_tag = 41;
    cycle();
    mt_if.src2_arch = 4;
    @(negedge clock);
    checks++; if (mt_if.T2 !== 7'd41 || mt_if.T2_ready !== 1'b0) begin errors++; $display("FAIL conflict_T2: got %0d/%b want 41/0", mt_if.T2, mt_if.T2_ready); end
    cycle();
  endtask

  task automatic test_recovery();
    mt_if.retire_en = 1; mt_if.retire_arch = 3; mt_if.retire_T_new = 40;
    cycle();
    mt_if.dispatch_en = 1; mt_if.dest_arch = 3; mt_if.free_reg = 42;
    @(negedge clock);
    checks++; if (mt_if.T_old !== 7'd40) begin errors++; $display("FAIL recov_T_old: got %0d want 40", mt_if.T_old); end
    cycle();
    mt_if.branch_incorrect = 1; mt_if.retire_en = 1; mt_if.retire_arch = 5; mt_if.retire_T_new = 50;
    mt_if.dispatch_en = 1; mt_if.dest_arch = 6; mt_if.free_reg = 43; mt_if.src1_arch = 3;
    @(negedge clock);
    checks++; if (mt_if.T1 !== 7'd42 || mt_if.T1_ready !== 1'b0) begin errors++; $display("FAIL recov_spec_T1: got %0d/%b want 42/0", mt_if.T1, mt_if.T1_ready); end
    cycle();
    mt_if.src1_arch = 3; mt_if.src2_arch = 5; mt_if.dest_arch = 6;
    @(negedge clock);
    checks++; if (mt_if.T1 !== 7'd40 || mt_if.T1_ready !== 1'b1) begin errors++; $display("FAIL recov_T1: got %0d/%b want 40/1", mt_if.T1, mt_if.T1_ready); end
    checks++; if (mt_if.T2 !== 7'd50 || mt_if.T2_ready !== 1'b1) begin errors++; $display("FAIL recov_retire_same_cycle: got %0d/%b want 50/1", mt_if.T2, mt_if.T2_ready); end
    checks++; if (mt_if.T_old !== 7'd6) begin errors++; $display("FAIL recov_dispatch_dropped: got %0d want 6", mt_if.T_old); end
    cycle();
  endtask

  task automatic test_zero_reg();
    mt_if.dispatch_en = 1; mt_if.dest_arch = 31; mt_if.free_reg = 44; mt_if.src1_arch = 31;
    @(negedge clock);
    checks++; if (mt_if.T_old !== 7'd63) begin errors++; $display("FAIL zero_T_old: got %0d want 63", mt_if.T_old); end
    cycle();
    mt_if.dispatch_en = 1; mt_if.id_no_dest_reg = 1; mt_if.dest_arch = 7; mt_if.free_reg = 45; mt_if.src1_arch = 31;
    @(negedge clock);
    checks++; if (mt_if.T1 !== 7'd63 || mt_if.T1_ready !== 1'b1) begin errors++; $display("FAIL zero_read: got %0d/%b want 63/1", mt_if.T1, mt_if.T1_ready); end
    checks++; if (mt_if.T_old !== 7'd63) begin errors++; $display("FAIL no_dest_T_old: got %0d want 63", mt_if.T_old); end
    cycle();
    mt_if.src1_arch = 7;
    @(negedge clock);
    checks++; if (mt_if.T1 !== 7'd7 || mt_if.T1_ready !== 1'b1) begin errors++; $display("FAIL no_dest_nowrite: got %0d/%b want 7/1", mt_if.T1, mt_if.T1_ready); end
    cycle();
  endtask

  task automatic test_random();
    PHYS_REG e1, e2, eo;
    bit r1, r2;
    for (int n = 0; n < 500; n++) begin
      mt_if.dispatch_en      = ($urandom_range(0, 3) != 0);
      mt_if.id_no_dest_reg   = ($urandom_range(0, 7) == 0);
      mt_if.dest_arch        = 5'($urandom_range(0, 31));
      mt_if.src1_arch        = 5'($urandom_range(0, 31));
      mt_if.src2_arch        = 5'($urandom_range(0, 31));
      mt_if.free_reg         = 7'($urandom_range(0, 63));
      mt_if.cdb_valid        = ($urandom_range(0, 1) != 0);
      mt_if.cdb_tag          = 7'(m_spec_tag[$urandom_range(0, 31)]);
      mt_if.retire_en        = ($urandom_range(0, 2) == 0);
      mt_if.retire_arch      = 5'($urandom_range(0, 31));
      mt_if.retire_T_new     = 7'($urandom_range(0, 63));
      mt_if.branch_incorrect = ($urandom_range(0, 19) == 0);
      @(negedge clock);
      e1 = exp_tag(int'(mt_if.src1_arch));
      e2 = exp_tag(int'(mt_if.src2_arch));
      r1 = exp_rdy(int'(mt_if.src1_arch), e1);
      r2 = exp_rdy(int'(mt_if.src2_arch), e2);
      eo = (mt_if.id_no_dest_reg || mt_if.dest_arch == ZR) ? PHYS_REG'(63) : exp_tag(int'(mt_if.dest_arch));
      checks++; if (mt_if.T1 !== e1) begin errors++; $display("FAIL rand_T1 n=%0d: got %0d want %0d", n, mt_if.T1, e1); end
      checks++; if (mt_if.T2 !== e2) begin errors++; $display("FAIL rand_T2 n=%0d: got %0d want %0d", n, mt_if.T2, e2); end
      checks++; if (mt_if.T1_ready !== r1) begin errors++; $display("FAIL rand_T1_ready n=%0d: got %b want %b", n, mt_if.T1_ready, r1); end
      checks++; if (mt_if.T2_ready !== r2) begin errors++; $display("FAIL rand_T2_ready n=%0d: got %b want %b", n, mt_if.T2_ready, r2); end
      checks++; if (mt_if.T_old !== eo) begin errors++; $display("FAIL rand_T_old n=%0d: got %0d want %0d", n, mt_if.T_old, eo); end
      cycle();
    end
  endtask

  task automatic test_async_reset();
    mt_if.dispatch_en = 1; mt_if.dest_arch = 9; mt_if.free_reg = 50; mt_if.src1_arch = 9;
    mt_if.retire_en = 1; mt_if.retire_arch = 9; mt_if.retire_T_new = 51;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    checks++; if (mt_if.T1 !== 7'd9 || mt_if.T1_ready !== 1'b1) begin errors++; $display("FAIL async_rst_T1: got %0d/%b want 9/1", mt_if.T1, mt_if.T1_ready); end
    checks++; if (mt_if.T_old !== 7'd9) begin errors++; $display("FAIL async_rst_T_old: got %0d want 9", mt_if.T_old); end
    @(posedge clock);
    #1;
    idle();
    mt_if.src1_arch = 9;
    @(negedge clock);
    checks++; if (mt_if.T1 !== 7'd9) begin errors++; $display("FAIL async_rst_held: got %0d want 9", mt_if.T1); end
    reset = 1'b1;
    cycle();
    mt_if.branch_incorrect = 1;
    cycle();
    mt_if.src2_arch = 9;
    @(negedge clock);
    checks++; if (mt_if.T2 !== 7'd9 || mt_if.T2_ready !== 1'b1) begin errors++; $display("FAIL async_rst_arch: got %0d/%b want 9/1", mt_if.T2, mt_if.T2_ready); end
    cycle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rename();
    test_cdb();
    test_conflict();
    test_recovery();
    test_zero_reg();
    test_random();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/map_table.md
MAP_TABLE -- requirements
Module: map_table

Interface
REQ-001 Parameter NUM_GEN_REG, default 32, number of architectural registers.
REQ-002 Parameter NUM_PHYS_REG, default 64, number of physical registers; PHYS_REG width is $clog2(NUM_PHYS_REG)+1.
REQ-003 Parameter ZERO_REG, default 31, index of the hard-wired zero architectural register.
REQ-004 Port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1, asynchronous active-low reset.
REQ-006 Port dispatch_en, input, 1, rename one instruction this cycle.
REQ-007 Port id_no_dest_reg, input, 1, the dispatched instruction writes no register.
REQ-008 Ports dest_arch, src1_arch, src2_arch, input, $clog2(NUM_GEN_REG) each, architectural indices.
REQ-009 Port free_reg, input, PHYS_REG, new tag popped from the free list.
REQ-010 Ports cdb_valid (1) and cdb_tag (PHYS_REG), input, completion broadcast.
REQ-011 Ports retire_en (1), retire_arch (index), retire_T_new (PHYS_REG), input, commit from the ROB.
REQ-012 Port branch_incorrect, input, 1, mispredict recovery request.
REQ-013 Ports T1, T2 (PHYS_REG) and T1_ready, T2_ready (1), output, renamed sources.
REQ-014 Port T_old, output, PHYS_REG, previous mapping of dest_arch, for the ROB.

Function
REQ-015 Holds a speculative map (tag + ready bit per arch reg) and an architectural map (tag only).
- Sources: T1/T2 and ready bits read the speculative map combinationally in the same cycle.
- Destination: T_old reads the speculative map combinationally in the same cycle.
- All reads return pre-update state.
REQ-016 dispatch_en & !id_no_dest_reg & dest_arch!=ZERO_REG: the speculative entry becomes {free_reg, ready=0} at the next edge.
REQ-017 id_no_dest_reg=1 or dest_arch==ZERO_REG: no write; T_old = {1'b0, all ones}.
REQ-018 Reads of ZERO_REG always return tag {1'b0, all ones} with ready=1.
REQ-019 cdb_valid: every speculative entry whose tag equals cdb_tag sets ready=1 at the next edge.
REQ-020 Same-cycle dispatch write and CDB match on the same entry: the dispatch write wins (ready=0).
REQ-021 retire_en: the architectural entry retire_arch takes retire_T_new at the next edge; writes to ZERO_REG are ignored.
REQ-022 branch_incorrect: at the next edge the speculative map takes every architectural tag (including a same-cycle retire write) with all ready=1.
- Dispatch and CDB updates in that cycle are discarded.
REQ-023 Latency: rename result is visible to a following dispatch one cycle later; there is no stall and no handshake.

Reset
REQ-024 While reset=0, entry i of both maps is tag i and every ready bit is 1.
- Asynchronous; takes effect mid-operation and discards pending updates.
REQ-025 With reset asserted, combinational outputs reflect the reset maps.

Configuration
REQ-026 Macro MT_CDB_BYPASS_EN defined: when cdb_valid and cdb_tag equals T1/T2, T1_ready/T2_ready read 1 in the same cycle.
- Undefined: ready reflects registered state only; the bypass appears one cycle later.

Structure
REQ-027 PHYS_REG typedef, NUM_GEN_REG, NUM_PHYS_REG and ZERO_REG live in the shared sys_defs package.
REQ-028 One sub-module, map_table_entry (tag + ready register with CDB compare), is instantiated per arch reg.

Verification
REQ-029 Reset: release, read src1_arch=5 -> T1=5, T1_ready=1.
REQ-030 Rename: dispatch dest_arch=3, free_reg=40 -> T_old=3 that cycle; next cycle src1_arch=3 gives T1=40, T1_ready=0.
REQ-031 CDB: cdb_tag=40 valid -> next cycle T1_ready=1 for arch 3; with MT_CDB_BYPASS_EN, T1_ready=1 in the same cycle.
REQ-032 Conflict: dispatch dest_arch=4, free_reg=41 while cdb_tag=41 -> arch 4 reads ready=0.
REQ-033 Recovery: retire arch 3 tag 40, rename arch 3->42, then branch_incorrect -> arch 3 reads 40, ready=1.
REQ-034 Zero register: dispatch dest_arch=31 -> no write; T_old=63; arch 31 reads tag 63, ready=1.
